// File: rtl/pll_reset_sequencer.sv
// PLL bring-up controller: drives pll_areset, waits for lock with a bounded
// timeout and retry budget, qualifies lock as stable before releasing the
// downstream reset, and re-sequences the PLL whenever lock is lost.
module pll_reset_sequencer #(
  parameter int unsigned ARESET_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_areset,
  output logic       rst_out,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] relock_count
);

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned RETRY_W  = 4;
  localparam int unsigned RELOCK_W = 8;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [RETRY_W-1:0]  retry_nxt;
  logic [RELOCK_W-1:0] relock_nxt;
  logic                locked_meta;
  logic                locked_s;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= pll_locked;
      locked_s    <= locked_meta;
    end
  end

  // State, cycle counter and event counters
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= ST_RESET_PLL;
      cnt          <= '0;
      retry_count  <= '0;
      relock_count <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      retry_count  <= retry_nxt;
      relock_count <= relock_nxt;
    end
  end

  // Next-state and counter update; force_relock outranks every transition
  always_comb begin
    state_nxt  = state;
    retry_nxt  = retry_count;
    relock_nxt = relock_count;

    if (force_relock) begin
      state_nxt = ST_RESET_PLL;
      retry_nxt = '0;
    end else begin
      case (state)
        ST_RESET_PLL: begin
          if (cnt == CNT_W'(ARESET_CYCLES - 1)) state_nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = ST_STABILIZE;
          end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            if (retry_count == RETRY_W'(MAX_RETRIES)) begin
              state_nxt = ST_FAIL;
            end else begin
              state_nxt = ST_RESET_PLL;
              retry_nxt = retry_count + RETRY_W'(1);
            end
          end
        end
        ST_STABILIZE: begin
          // Lock counted from the STABILIZE entry cycle so release lands
          // STABLE_CYCLES+3 edges after the raw lock is first sampled
          if (!locked_s) begin
            state_nxt = ST_WAIT_LOCK;
          end else if (cnt == CNT_W'(STABLE_CYCLES)) begin
            state_nxt = ST_RUN;
            retry_nxt = '0;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_nxt = ST_RESET_PLL;
            if (relock_count != '1) relock_nxt = relock_count + RELOCK_W'(1);
          end
        end
        ST_FAIL: begin
          state_nxt = ST_FAIL;
        end
        default: begin
          state_nxt = ST_RESET_PLL;
        end
      endcase
    end

    // Counter restarts on any state change or forced restart, never wraps
    if (force_relock || (state_nxt != state)) begin
      cnt_nxt = '0;
    end else if (cnt == '1) begin
      cnt_nxt = cnt;
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Moore output decode from the state register
  always_comb begin
    pll_areset = 1'b0;
    rst_out    = 1'b1;
    ready      = 1'b0;
    fail       = 1'b0;
    case (state)
      ST_RESET_PLL: pll_areset = 1'b1;
      ST_RUN: begin
        rst_out = 1'b0;
        ready   = 1'b1;
      end
      ST_FAIL: begin
        pll_areset = 1'b1;
        fail       = 1'b1;
      end
      default: pll_areset = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: per-cycle vector table plus a
// hand-written asynchronous reset sequence.
module tb_pll_reset_sequencer;

  localparam int unsigned ARESET_CYCLES = 4;
  localparam int unsigned LOCK_TIMEOUT  = 20;
  localparam int unsigned STABLE_CYCLES = 8;
  localparam int unsigned MAX_RETRIES   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_areset;
  logic       rst_out;
  logic       ready;
  logic       fail;
  logic [3:0] retry_count;
  logic [7:0] relock_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        rst_i;
    logic        lck;
    logic        frc;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  pll_reset_sequencer #(
    .ARESET_CYCLES(ARESET_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .force_relock(force_relock),
    .pll_areset  (pll_areset),
    .rst_out     (rst_out),
    .ready       (ready),
    .fail        (fail),
    .retry_count (retry_count),
    .relock_count(relock_count)
  );

  always #10 clk = ~clk;

  function automatic logic [15:0] pack(input logic ar, input logic ro, input logic rd,
                                       input logic fl, input logic [3:0] rc,
                                       input logic [7:0] lc);
    return {ar, ro, rd, fl, rc, lc};
  endfunction

  task automatic add(input string tag, input int n, input logic r, input logic l,
                     input logic f, input logic ar, input logic ro, input logic rd,
                     input logic fl, input logic [3:0] rc, input logic [7:0] lc);
    vec_t v;
    v.tag   = tag;
    v.rst_i = r;
    v.lck   = l;
    v.frc   = f;
    v.exp   = pack(ar, ro, rd, fl, rc, lc);
    repeat (n) vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [15:0] exp);
    logic [15:0] got;
    got = {pll_areset, rst_out, ready, fail, retry_count, relock_count};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got areset=%b rst_out=%b ready=%b fail=%b retry=%0d relock=%0d, expected areset=%b rst_out=%b ready=%b fail=%b retry=%0d relock=%0d",
               name, idx, got[15], got[14], got[13], got[12], got[11:8], got[7:0],
               exp[15], exp[14], exp[13], exp[12], exp[11:8], exp[7:0]);
    end
  endtask

  initial begin
    reset        = 1'b1;
    pll_locked   = 1'b0;
    force_relock = 1'b0;

    // Lock glitch in STABILIZE: lock raised at row 10, dropped for row 17
    add("glitch_rst",  2, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    add("glitch",      3, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add("glitch",      7, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add("glitch",      7, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add("glitch",      1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add("glitch",     11, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add("glitch_run",  2, 0, 1, 0, 0, 0, 1, 0, 0, 0);

    // Timeout, retries, FAIL, then force_relock recovery
    add("timeout_rst", 2, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    add("try0_areset", 3, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add("try0_wait",  20, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add("try1_areset", 4, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    add("try1_wait",  20, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    add("try2_areset", 4, 0, 0, 0, 1, 1, 0, 0, 2, 0);
    add("try2_wait",  20, 0, 0, 0, 0, 1, 0, 0, 2, 0);
    add("fail_hold",   5, 0, 0, 0, 1, 1, 0, 1, 2, 0);
    add("fail_force",  1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add("fail_restart",3, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add("fail_restart",2, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Normal bring-up: lock raised at row 10, release 11 edges later
    add("bringup_rst", 2, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    add("bringup",     3, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add("bringup",     7, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add("bringup",    11, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add("bringup_run", 1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    // Lock falls so locked_s is low on the same edge force_relock is seen
    add("run_drop",    2, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add("force_run",   1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add("force_areset",3, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add("force_wait",  2, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add("force_relck",11, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add("force_run2",  3, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    // Loss of lock in RUN
    add("loss_run",    2, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add("loss_areset", 4, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    add("loss_relock",11, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    add("loss_run2",   3, 0, 1, 0, 0, 0, 1, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      reset        = vecs[i].rst_i;
      pll_locked   = vecs[i].lck;
      force_relock = vecs[i].frc;
      @(negedge clk);
      check(vecs[i].tag, i, vecs[i].exp);
    end

    // Async reset mid-STABILIZE with nonzero relock_count
    pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    pll_locked = 1'b1;
    @(negedge clk);
    check("relock2", 0, pack(1, 1, 0, 0, 4'd0, 8'd2));
    repeat (5) @(negedge clk);
    check("stabilize_pre", 0, pack(0, 1, 0, 0, 4'd0, 8'd2));
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_now", 0, pack(1, 1, 0, 0, 4'd0, 8'd0));
    @(negedge clk);
    check("async_rst_hold", 0, pack(1, 1, 0, 0, 4'd0, 8'd0));
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("restart", k, pack(k < 3, k < 13, k >= 13, 1'b0, 4'd0, 8'd0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Controller for the system PLL (inclk0/c0/locked). It drives the PLL's areset, waits for lock with a timeout and bounded retries, and qualifies lock as stable before releasing the downstream reset. On loss of lock it re-sequences the PLL. Sits between the PLL instance and all logic clocked from CLOCK_200, and runs on CLOCK_50.

Parameters:
ARESET_CYCLES, 16, cycles pll_areset is held high per attempt (1..65535)
LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before an attempt fails (1..65535)
STABLE_CYCLES, 256, consecutive synchronized-lock cycles required before release (1..65535)
MAX_RETRIES, 3, failed attempts tolerated before FAIL (0..15)

Ports:
CLOCK_50  in  1  reference clock, also drives the PLL inclk0
reset  in  1  asynchronous, active-high
pll_locked  in  1  PLL locked output, asynchronous to CLOCK_50
force_relock  in  1  synchronous pulse that restarts the sequence
pll_areset  out  1  PLL areset, active-high
rst_out  out  1  downstream reset, active-high
ready  out  1  high only in RUN
fail  out  1  high only in FAIL
retry_count  out  4  failed attempts in the current sequence
relock_count  out  8  lock-loss events since reset, saturating at 255

Behaviour:
- reset high: state RESET_PLL, all counters 0, sync flops 0; pll_areset=1, rst_out=1, ready=0, fail=0, retry_count=0, relock_count=0.
- pll_locked passes through a 2-flop synchronizer (locked_s). The state machine uses only locked_s.
- Moore outputs are decoded from the state register. A single 16-bit cycle counter cnt clears on every state change.
- RESET_PLL: pll_areset=1, rst_out=1. Stays exactly ARESET_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK: pll_areset=0, rst_out=1.
  - locked_s=1: go to STABILIZE.
  - Otherwise, when cnt reaches LOCK_TIMEOUT-1: if retry_count==MAX_RETRIES go to FAIL; else retry_count+1 and go to RESET_PLL.
- STABILIZE: pll_areset=0, rst_out=1.
  - locked_s=0: go back to WAIT_LOCK with a fresh timeout; retry_count is unchanged.
  - After STABLE_CYCLES consecutive high cycles: go to RUN.
- RUN: rst_out=0, ready=1. retry_count clears on entry.
  - locked_s=0: go to RESET_PLL and increment relock_count (saturating).
  - rst_out reasserts on the edge after locked_s is sampled low.
- FAIL: pll_areset=1, rst_out=1, fail=1. Exits only via reset or force_relock.
- force_relock=1 in any state: go to RESET_PLL on the next edge and clear retry_count; relock_count is unchanged. It has priority over all other transitions; only reset outranks it.
- Release latency: with pll_locked rising cleanly during WAIT_LOCK, rst_out falls exactly STABLE_CYCLES+3 edges after the first edge sampling pll_locked=1.
- Reset asserted mid-sequence: outputs return to reset values asynchronously, with no glitch low on rst_out.
- Counters never wrap; cnt comparisons use ==.
- Unused state encodings return to RESET_PLL.

Test Plan:
Bench parameters: ARESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Normal bring-up: release reset, pll_locked rises 10 cycles later -> pll_areset high exactly 4 cycles, then rst_out falls 11 edges after lock is sampled; ready=1, retry_count=0.
2. Lock glitch in STABILIZE: pll_locked drops for 1 cycle after 5 stable cycles -> back to WAIT_LOCK, full 8-cycle stability count restarts, retry_count stays 0, rst_out stays 1 until then.
3. Timeout/retry/fail: pll_locked held 0 -> three 4-cycle areset pulses separated by 20-cycle waits, retry_count 0->1->2, then fail=1 with pll_areset=1 held; asserting force_relock -> retry_count=0 and sequence restarts.
4. Loss of lock in RUN: drop pll_locked -> rst_out=1 and ready=0 within 3 edges, relock_count=1, pll_areset pulses 4 cycles; restore lock -> RUN again.
5. force_relock in RUN coincident with pll_locked falling -> force_relock path taken, relock_count unchanged (0).
6. Async reset asserted mid-STABILIZE, not clock-aligned -> rst_out=1, pll_areset=1 and counters 0 immediately; sequence restarts from RESET_PLL after release.
